quick_spi_slave: RTL and testbench
==================================

// Module: quick_spi_slave
// PURPOSE
//  SPI responder (slave) for the quick_spi master: receives LSB-first command/data frames on mosi and returns an LSB-first reply on miso.
//  Oversamples sclk/ss_n/mosi in the local clk domain, so no sclk-clocked logic.
//  Sits in peripheral FPGAs/test fixtures that a quick_spi master addresses through one ss_n line.
// PARAMETERS
//  RX_DATA_WIDTH  16  bits received per frame on mosi (matches master OUTGOING_DATA_WIDTH)
//  TX_DATA_WIDTH  8   reply bits shifted out on miso (matches master INCOMING_DATA_WIDTH)
//  TX_SKIP_BITS   18  sample edges counted before the first reply bit is driven
//  CPOL           0   sclk idle level
//  CPHA           0   0: sample on leading edge; 1: sample on trailing edge
//  SYNC_STAGES    2   synchronizer depth for sclk, ss_n, mosi (>=2)
// PORTS
//  clk          in   1              system clock, >= 8x sclk frequency
//  reset_n      in   1              asynchronous, active-low reset
//  enable       in   1              0: ignore bus, miso_oe held 0
//  ss_n         in   1              slave select, active low
//  sclk         in   1              SPI clock from master
//  mosi         in   1              master-out data
//  miso         out  1              slave-out data
//  miso_oe      out  1              1 while selected; top level tristates miso when 0
//  tx_data      in   TX_DATA_WIDTH  reply word
//  tx_load      in   1              capture tx_data when tx_ready=1
//  tx_ready     out  1              1 in IDLE (reply register writable)
//  rx_data      out  RX_DATA_WIDTH  last complete received word
//  rx_valid     out  1              one-cycle pulse, rx_data updated
//  frame_error  out  1              one-cycle pulse, ss_n released before RX_DATA_WIDTH bits
//  busy         out  1              1 in SHIFT or FLUSH
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, frame_error=0, busy=0, state=IDLE, counters 0, reply reg 0.
//  Inputs pass SYNC_STAGES flops, then a 1-flop history for edge detection.
//  Leading edge = synced sclk leaves CPOL level; trailing = returns to it.
//  Sample edge = leading (CPHA=0) / trailing (CPHA=1); shift edge is the other.
//  FSM:
//   IDLE: tx_load & tx_ready latch tx_data.
//    Synced ss_n falling & enable -> SHIFT; miso_oe<=1, bit_cnt<=0, miso<=0.
//   SHIFT, on sample edge: rx_shift <= {mosi, rx_shift[RX-1:1]} while bit_cnt<RX_DATA_WIDTH.
//    On the same edge, bit_cnt++ (saturates at RX_DATA_WIDTH+TX_SKIP_BITS+TX_DATA_WIDTH).
//    When bit_cnt reaches RX_DATA_WIDTH: rx_data<=rx_shift, rx_valid pulse next cycle.
//    On shift edge (or on entry if CPHA=0 and TX_SKIP_BITS==0): if bit_cnt>=TX_SKIP_BITS and reply bits remain, miso<=reply[0], reply>>=1; else miso<=0.
//    Synced ss_n rising -> FLUSH.
//   FLUSH (1 cycle): miso_oe<=0, miso<=0.
//    If bit_cnt<RX_DATA_WIDTH, pulse frame_error and leave rx_data unchanged.
//    Clear shift regs -> IDLE.
//  Latency: rx_valid asserts SYNC_STAGES+2 clk after the final sampling sclk edge at the pins.
//  Bits past RX_DATA_WIDTH on mosi are ignored; a reply exhausted early drives 0.
//  enable deasserted mid-frame: finish current frame, then refuse new ones.
//  tx_load while busy is ignored; reply reg is not reloaded between frames.
//   The next frame resends the last loaded word's bits from bit0 (a copy is kept).
//  ss_n fall and rise within 2 clk: treated as zero-bit frame -> frame_error.
//  Async reset mid-frame: all outputs to reset values immediately.
//   The remaining frame is ignored until ss_n returns high then falls.
// STRUCTURE
//  quick_spi_defs.vh: state encodings (IDLE/SHIFT/FLUSH), mode helpers LEAD_IS_SAMPLE = (CPHA==0).
//  Sub-module spi_input_sync: SYNC_STAGES synchronizer + rise/fall strobes.
//   Three instances: sclk, ss_n, mosi (mosi without strobes).
//  Top holds FSM, bit counter, rx/reply shift registers.
// TESTING
//  1 Reset: drive frame, assert reset_n low after 5 bits -> miso_oe=0 same cycle, no rx_valid, no frame_error. Next full frame is received correctly.
//  2 Mode 0, quick_spi master writes 16'hA5C3 -> single rx_valid, rx_data=16'hA5C3, miso_oe low after ss_n high.
//  3 Read: tx_load 8'h5A in IDLE, master read (16 cmd bits, extra toggles) -> miso 0 during skip, master incoming_data=8'h5A.
//  4 Abort: ss_n high after 7 bits -> frame_error 1 cycle, rx_data unchanged. Then a full 16'h0001 frame -> rx_valid, rx_data=16'h0001.
//  5 CPOL=1/CPHA=1 build: repeat 2 and 3 -> same values.
//  6 tx_load 8'hFF while busy -> ignored; next frame still returns 8'h5A.

Source files
------------

// File: rtl/quick_spi_slave_pkg.sv
// Shared definitions for the quick_spi responder.
//   state_e        : controller states
//   lead_is_sample : 1 when the leading sclk edge is the sampling edge (CPHA = 0)
package quick_spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic bit lead_is_sample(input int cpha);
    return (cpha == 0);
  endfunction

endpackage

// File: rtl/quick_spi_slave_sync.sv
// Multi-flop synchronizer that brings one asynchronous SPI pin into clk.
//   clk, reset_n : local clock, async active-low reset
//   d            : asynchronous pin
//   q            : synchronized level, SYNC_STAGES clk later
// The chain resets to 0. A reset taken while ss_n is low therefore does not
// create a falling edge on release, so a partial frame is not picked up.
module quick_spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder for the quick_spi master. It oversamples sclk, ss_n and mosi
// in clk and handles LSB-first frames in both directions.
//   enable            : accept new frames (a frame in progress always completes)
//   ss_n, sclk, mosi  : SPI bus inputs
//   miso, miso_oe     : reply bit and its output enable (tristate at top level)
//   tx_data, tx_load  : reply word, captured while tx_ready = 1
//   tx_ready, busy    : idle / frame in progress
//   rx_data, rx_valid : last full received word, with a one-cycle strobe
//   frame_error       : one-cycle strobe, ss_n released before a full word
//
// state  | meaning
// IDLE   | waiting for ss_n fall; reply word may be loaded
// SHIFT  | selected: sample mosi, shift reply out on miso
// FLUSH  | one cycle after ss_n rise: release miso, flag short frame
module quick_spi_slave
  import quick_spi_slave_pkg::*;
#(
  parameter int RX_DATA_WIDTH = 16,
  parameter int TX_DATA_WIDTH = 8,
  parameter int TX_SKIP_BITS  = 18,
  parameter int CPOL          = 0,
  parameter int CPHA          = 0,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     ss_n,
  input  logic                     sclk,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [TX_DATA_WIDTH-1:0] tx_data,
  input  logic                     tx_load,
  output logic                     tx_ready,
  output logic [RX_DATA_WIDTH-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     frame_error,
  output logic                     busy
);

  localparam int CNT_MAX = RX_DATA_WIDTH + TX_SKIP_BITS + TX_DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TXC_W   = $clog2(TX_DATA_WIDTH + 1);
  localparam bit LEAD_SAMPLE = lead_is_sample(CPHA);
  localparam logic [CNT_W-1:0] RX_CNT   = CNT_W'(RX_DATA_WIDTH);
  localparam logic [CNT_W-1:0] SKIP_CNT = CNT_W'(TX_SKIP_BITS);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(CNT_MAX);
  localparam logic [TXC_W-1:0] TX_CNT   = TXC_W'(TX_DATA_WIDTH);

  logic sclk_s, ss_n_s, mosi_s;

  quick_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(sclk), .q(sclk_s));
  quick_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss_n (
    .clk(clk), .reset_n(reset_n), .d(ss_n), .q(ss_n_s));
  quick_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s));

  state_e                   state_q, state_d;
  logic                     sclk_hist_q, sclk_hist_d;
  logic                     ss_hist_q, ss_hist_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [TXC_W-1:0]         tx_left_q, tx_left_d;
  logic [RX_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [RX_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [TX_DATA_WIDTH-1:0] reply_q, reply_d;
  logic [TX_DATA_WIDTH-1:0] reply_copy_q, reply_copy_d;
  logic                     rx_pend_q, rx_pend_d;
  logic                     miso_q, miso_d;
  logic                     miso_oe_q, miso_oe_d;
  logic                     tx_ready_q, tx_ready_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     frame_error_q, frame_error_d;
  logic                     busy_q, busy_d;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  always_comb begin
    sclk_rise   = sclk_s & ~sclk_hist_q;
    sclk_fall   = ~sclk_s & sclk_hist_q;
    lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
    trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
    sample_edge = LEAD_SAMPLE ? lead_edge : trail_edge;
    shift_edge  = LEAD_SAMPLE ? trail_edge : lead_edge;
    ss_fall     = ~ss_n_s & ss_hist_q;
    ss_rise     = ss_n_s & ~ss_hist_q;
  end

  always_comb begin
    state_d       = state_q;
    sclk_hist_d   = sclk_s;
    ss_hist_d     = ss_n_s;
    bit_cnt_d     = bit_cnt_q;
    tx_left_d     = tx_left_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    reply_d       = reply_q;
    reply_copy_d  = reply_copy_q;
    rx_pend_d     = rx_pend_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    // The word completed on the previous cycle is published here, whatever
    // state the controller has moved on to.
    if (rx_pend_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      rx_pend_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_load && tx_ready_q) begin
          reply_copy_d = tx_data;
        end
        if (ss_fall && enable) begin
          state_d   = ST_SHIFT;
          miso_oe_d = 1'b1;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          reply_d   = reply_copy_q;
          tx_left_d = TX_CNT;
          // With no skip and sampling on the leading edge, the first reply
          // bit must already be on miso before the first sclk edge.
          if (LEAD_SAMPLE && TX_SKIP_BITS == 0) begin
            miso_d    = reply_copy_q[0];
            reply_d   = reply_copy_q >> 1;
            tx_left_d = TX_CNT - TXC_W'(1);
          end
        end
      end

      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_FLUSH;
        end else begin
          if (sample_edge) begin
            if (bit_cnt_q < RX_CNT) begin
              rx_shift_d = {mosi_s, rx_shift_q[RX_DATA_WIDTH-1:1]};
              if (bit_cnt_q == RX_CNT - CNT_W'(1)) begin
                rx_pend_d = 1'b1;
              end
            end
            if (bit_cnt_q < MAX_CNT) begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (shift_edge) begin
            if (bit_cnt_q >= SKIP_CNT && tx_left_q != '0) begin
              miso_d    = reply_q[0];
              reply_d   = reply_q >> 1;
              tx_left_d = tx_left_q - TXC_W'(1);
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      end

      ST_FLUSH: begin
        miso_oe_d = 1'b0;
        miso_d    = 1'b0;
        if (bit_cnt_q < RX_CNT) begin
          frame_error_d = 1'b1;
        end
        rx_shift_d = '0;
        reply_d    = '0;
        tx_left_d  = '0;
        bit_cnt_d  = '0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sclk_hist_q   <= 1'b0;
      ss_hist_q     <= 1'b0;
      bit_cnt_q     <= '0;
      tx_left_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      reply_q       <= '0;
      reply_copy_q  <= '0;
      rx_pend_q     <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_hist_q   <= sclk_hist_d;
      ss_hist_q     <= ss_hist_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_left_q     <= tx_left_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      reply_q       <= reply_d;
      reply_copy_q  <= reply_copy_d;
      rx_pend_q     <= rx_pend_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      tx_ready_q    <= tx_ready_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: one mode-0 instance (a) and one CPOL=1/CPHA=1
// instance (b) on a shared bus with separate selects, driven by a behavioural
// SPI master and compared against a bit-position reply/receive model.
module tb_quick_spi_slave;

  localparam int RXW  = 16;
  localparam int TXW  = 8;
  localparam int SKIP = 18;
  localparam int HALF = 60;

  logic clk, reset_n, enable, sclk, mosi;
  logic [TXW-1:0] tx_data;
  logic ss_n_a, tx_load_a, miso_a, miso_oe_a, tx_ready_a, rx_valid_a, frame_error_a, busy_a;
  logic ss_n_b, tx_load_b, miso_b, miso_oe_b, tx_ready_b, rx_valid_b, frame_error_b, busy_b;
  logic [RXW-1:0] rx_data_a, rx_data_b;

  int checks = 0;
  int failures = 0;

  int rxv_a = 0, fe_a = 0, rxv_b = 0, fe_b = 0;
  logic [RXW-1:0] seen_a = '0, seen_b = '0;

  logic oe_seen, oe_in_reset;
  logic [TXW-1:0] ref_word_a = '0, ref_word_b = '0;
  logic [RXW-1:0] ref_rx_a = '0, ref_rx_b = '0;

  quick_spi_slave #(.RX_DATA_WIDTH(RXW), .TX_DATA_WIDTH(TXW), .TX_SKIP_BITS(SKIP),
                    .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ss_n(ss_n_a), .sclk(sclk),
    .mosi(mosi), .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_data),
    .tx_load(tx_load_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .frame_error(frame_error_a), .busy(busy_a));

  quick_spi_slave #(.RX_DATA_WIDTH(RXW), .TX_DATA_WIDTH(TXW), .TX_SKIP_BITS(SKIP),
                    .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ss_n(ss_n_b), .sclk(sclk),
    .mosi(mosi), .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_data),
    .tx_load(tx_load_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .frame_error(frame_error_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors: counting high cycles means a count step of exactly one
  // also proves a single-cycle pulse.
  always @(negedge clk) begin
    if (rx_valid_a) begin rxv_a++; seen_a = rx_data_a; end
    if (frame_error_a) fe_a++;
    if (rx_valid_b) begin rxv_b++; seen_b = rx_data_b; end
    if (frame_error_b) fe_b++;
  end

  function automatic int get_rxv(input bit s); return s ? rxv_b : rxv_a; endfunction
  function automatic int get_fe(input bit s); return s ? fe_b : fe_a; endfunction
  function automatic logic [RXW-1:0] get_seen(input bit s); return s ? seen_b : seen_a; endfunction
  function automatic logic [RXW-1:0] get_rxd(input bit s); return s ? rx_data_b : rx_data_a; endfunction

  // Reference: the master's sample number i returns reply bit (i - SKIP)
  // while it lies inside the word, zero everywhere else.
  function automatic logic [63:0] model_miso(input logic [TXW-1:0] word, input int nbits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++)
      if (i >= SKIP && i < SKIP + TXW) r[i] = word[i - SKIP];
    return r;
  endfunction

  task automatic load_word(input bit s, input logic [TXW-1:0] w);
    @(negedge clk);
    tx_data = w;
    if (s) tx_load_b = 1'b1; else tx_load_a = 1'b1;
    @(negedge clk);
    tx_load_a = 1'b0;
    tx_load_b = 1'b0;
  endtask

  // Behavioural master. Mode 0 for instance a, mode 3 for instance b.
  task automatic run_frame(input bit s, input int nbits, input logic [63:0] bits,
                           input int reset_at, output logic [63:0] mb);
    mb = '0;
    oe_seen = 1'b0;
    oe_in_reset = 1'b1;
    sclk = s;
    #(HALF);
    if (s) ss_n_b = 1'b0; else ss_n_a = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        reset_n = 1'b0;
        #1;
        oe_in_reset = s ? miso_oe_b : miso_oe_a;
        #19;
        reset_n = 1'b1;
      end
      if (!s) begin
        mosi = bits[i];
        #(HALF);
        sclk = 1'b1;
        mb[i] = miso_a;
        oe_seen = oe_seen | miso_oe_a;
        #(HALF);
        sclk = 1'b0;
      end else begin
        sclk = 1'b0;
        mosi = bits[i];
        #(HALF);
        sclk = 1'b1;
        mb[i] = miso_b;
        oe_seen = oe_seen | miso_oe_b;
        #(HALF);
      end
    end
    #(HALF);
    ss_n_a = 1'b1;
    ss_n_b = 1'b1;
    #(4*HALF);
  endtask

  task automatic test_reset();
    logic [63:0] d, mb;
    int rv0, fe0;
    checks++;
    if ({miso_a, miso_oe_a, tx_ready_a, rx_valid_a, frame_error_a, busy_a, rx_data_a} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL reset_a got=%b exp=%b", {miso_a, miso_oe_a, tx_ready_a, rx_valid_a,
               frame_error_a, busy_a, rx_data_a}, {6'b001000, 16'h0});
    end
    checks++;
    if ({miso_b, miso_oe_b, tx_ready_b, rx_valid_b, frame_error_b, busy_b, rx_data_b} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL reset_b got=%b exp=%b", {miso_b, miso_oe_b, tx_ready_b, rx_valid_b,
               frame_error_b, busy_b, rx_data_b}, {6'b001000, 16'h0});
    end
    rv0 = rxv_a; fe0 = fe_a;
    d = {$urandom, $urandom};
    run_frame(1'b0, RXW, d, 5, mb);
    checks++;
    if (oe_in_reset !== 1'b0) begin
      failures++; $display("FAIL reset_oe got=%b exp=0", oe_in_reset);
    end
    checks++;
    if (rxv_a - rv0 !== 0) begin
      failures++; $display("FAIL reset_rxv got=%0d exp=0", rxv_a - rv0);
    end
    checks++;
    if (fe_a - fe0 !== 0) begin
      failures++; $display("FAIL reset_fe got=%0d exp=0", fe_a - fe0);
    end
    ref_word_a = '0; ref_word_b = '0; ref_rx_a = '0; ref_rx_b = '0;
    rv0 = rxv_a;
    d = {$urandom, $urandom};
    run_frame(1'b0, RXW, d, -1, mb);
    checks++;
    if (rxv_a - rv0 !== 1 || seen_a !== d[15:0]) begin
      failures++;
      $display("FAIL reset_next got=%0d/%h exp=1/%h", rxv_a - rv0, seen_a, d[15:0]);
    end
    ref_rx_a = d[15:0];
  endtask

  task automatic test_write(input bit s, input logic [RXW-1:0] w);
    logic [63:0] mb;
    int rv0, fe0;
    rv0 = get_rxv(s); fe0 = get_fe(s);
    run_frame(s, RXW, {48'h0, w}, -1, mb);
    checks++;
    if (get_rxv(s) - rv0 !== 1) begin
      failures++; $display("FAIL write%0d rxv got=%0d exp=1", s, get_rxv(s) - rv0);
    end
    checks++;
    if (get_seen(s) !== w) begin
      failures++; $display("FAIL write%0d data got=%h exp=%h", s, get_seen(s), w);
    end
    checks++;
    if (get_fe(s) - fe0 !== 0) begin
      failures++; $display("FAIL write%0d fe got=%0d exp=0", s, get_fe(s) - fe0);
    end
    checks++;
    if (oe_seen !== 1'b1 || (s ? miso_oe_b : miso_oe_a) !== 1'b0) begin
      failures++;
      $display("FAIL write%0d oe during=%b after=%b exp=1/0", s, oe_seen, s ? miso_oe_b : miso_oe_a);
    end
    if (s) ref_rx_b = w; else ref_rx_a = w;
  endtask

  task automatic test_read(input bit s);
    logic [63:0] d, mb, exp;
    checks++;
    if ((s ? tx_ready_b : tx_ready_a) !== 1'b1) begin
      failures++; $display("FAIL read%0d tx_ready got=0 exp=1", s);
    end
    load_word(s, 8'h5A);
    if (s) ref_word_b = 8'h5A; else ref_word_a = 8'h5A;
    d = {$urandom, $urandom};
    run_frame(s, SKIP + TXW, d, -1, mb);
    exp = model_miso(8'h5A, SKIP + TXW);
    checks++;
    if (mb[SKIP-1:0] !== '0) begin
      failures++; $display("FAIL read%0d skip got=%h exp=0", s, mb[SKIP-1:0]);
    end
    checks++;
    if (mb[SKIP+TXW-1:SKIP] !== 8'h5A) begin
      failures++; $display("FAIL read%0d incoming got=%h exp=5a", s, mb[SKIP+TXW-1:SKIP]);
    end
    checks++;
    if (mb !== exp) begin
      failures++; $display("FAIL read%0d miso got=%h exp=%h", s, mb, exp);
    end
    checks++;
    if (get_seen(s) !== d[15:0]) begin
      failures++; $display("FAIL read%0d cmd got=%h exp=%h", s, get_seen(s), d[15:0]);
    end
    if (s) ref_rx_b = d[15:0]; else ref_rx_a = d[15:0];
  endtask

  task automatic test_abort(input bit s);
    logic [63:0] mb;
    int rv0, fe0;
    rv0 = get_rxv(s); fe0 = get_fe(s);
    run_frame(s, 7, {$urandom, $urandom}, -1, mb);
    checks++;
    if (get_fe(s) - fe0 !== 1) begin
      failures++; $display("FAIL abort%0d fe got=%0d exp=1", s, get_fe(s) - fe0);
    end
    checks++;
    if (get_rxv(s) - rv0 !== 0) begin
      failures++; $display("FAIL abort%0d rxv got=%0d exp=0", s, get_rxv(s) - rv0);
    end
    checks++;
    if (get_rxd(s) !== (s ? ref_rx_b : ref_rx_a)) begin
      failures++;
      $display("FAIL abort%0d rx_data got=%h exp=%h", s, get_rxd(s), s ? ref_rx_b : ref_rx_a);
    end
    rv0 = get_rxv(s);
    run_frame(s, RXW, 64'h1, -1, mb);
    checks++;
    if (get_rxv(s) - rv0 !== 1 || get_seen(s) !== 16'h0001) begin
      failures++;
      $display("FAIL abort%0d recover got=%0d/%h exp=1/0001", s, get_rxv(s) - rv0, get_seen(s));
    end
    if (s) ref_rx_b = 16'h0001; else ref_rx_a = 16'h0001;
  endtask

  task automatic test_load_busy(input bit s);
    logic [63:0] mb;
    logic busy_at_load;
    logic [TXW-1:0] w;
    w = s ? ref_word_b : ref_word_a;
    busy_at_load = 1'b0;
    fork
      run_frame(s, SKIP + TXW, {$urandom, $urandom}, -1, mb);
      begin
        #(6*HALF);
        @(negedge clk);
        busy_at_load = s ? busy_b : busy_a;
        tx_data = 8'hFF;
        if (s) tx_load_b = 1'b1; else tx_load_a = 1'b1;
        @(negedge clk);
        tx_load_a = 1'b0;
        tx_load_b = 1'b0;
      end
    join
    checks++;
    if (busy_at_load !== 1'b1) begin
      failures++; $display("FAIL busy%0d busy got=%b exp=1", s, busy_at_load);
    end
    checks++;
    if (mb[SKIP+TXW-1:SKIP] !== w) begin
      failures++; $display("FAIL busy%0d reply got=%h exp=%h", s, mb[SKIP+TXW-1:SKIP], w);
    end
    run_frame(s, SKIP + TXW, {$urandom, $urandom}, -1, mb);
    checks++;
    if (mb[SKIP+TXW-1:SKIP] !== w) begin
      failures++; $display("FAIL busy%0d resend got=%h exp=%h", s, mb[SKIP+TXW-1:SKIP], w);
    end
    if (s) ref_rx_b = seen_b; else ref_rx_a = seen_a;
  endtask

  task automatic test_enable();
    logic [63:0] mb, d;
    int rv0;
    enable = 1'b0;
    rv0 = rxv_a;
    run_frame(1'b0, RXW, {$urandom, $urandom}, -1, mb);
    checks++;
    if (rxv_a - rv0 !== 0 || oe_seen !== 1'b0) begin
      failures++; $display("FAIL enable_off rxv=%0d oe=%b exp=0/0", rxv_a - rv0, oe_seen);
    end
    enable = 1'b1;
    rv0 = rxv_a;
    d = {$urandom, $urandom};
    fork
      run_frame(1'b0, RXW, d, -1, mb);
      begin #(8*HALF); enable = 1'b0; end
    join
    checks++;
    if (rxv_a - rv0 !== 1 || seen_a !== d[15:0]) begin
      failures++;
      $display("FAIL enable_drop got=%0d/%h exp=1/%h", rxv_a - rv0, seen_a, d[15:0]);
    end
    ref_rx_a = d[15:0];
    rv0 = rxv_a;
    run_frame(1'b0, RXW, {$urandom, $urandom}, -1, mb);
    checks++;
    if (rxv_a - rv0 !== 0) begin
      failures++; $display("FAIL enable_refuse rxv got=%0d exp=0", rxv_a - rv0);
    end
    enable = 1'b1;
  endtask

  task automatic test_random(input bit s, input int n);
    logic [63:0] d, mb, exp;
    logic [TXW-1:0] w;
    int nb, rv0, fe0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = TXW'($urandom);
        load_word(s, w);
        if (s) ref_word_b = w; else ref_word_a = w;
      end
      nb = $urandom_range(0, 44);
      d = {$urandom, $urandom};
      rv0 = get_rxv(s); fe0 = get_fe(s);
      run_frame(s, nb, d, -1, mb);
      exp = model_miso(s ? ref_word_b : ref_word_a, nb);
      if (nb >= RXW) begin
        if (s) ref_rx_b = d[15:0]; else ref_rx_a = d[15:0];
      end
      checks++;
      if (mb !== exp) begin
        failures++; $display("FAIL rand%0d[%0d] n=%0d miso got=%h exp=%h", s, k, nb, mb, exp);
      end
      checks++;
      if (get_rxv(s) - rv0 !== ((nb >= RXW) ? 1 : 0) || get_fe(s) - fe0 !== ((nb < RXW) ? 1 : 0)) begin
        failures++;
        $display("FAIL rand%0d[%0d] n=%0d rxv=%0d fe=%0d", s, k, nb, get_rxv(s) - rv0, get_fe(s) - fe0);
      end
      checks++;
      if (get_rxd(s) !== (s ? ref_rx_b : ref_rx_a)) begin
        failures++;
        $display("FAIL rand%0d[%0d] rx_data got=%h exp=%h", s, k, get_rxd(s), s ? ref_rx_b : ref_rx_a);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_data = '0;
    ss_n_a = 1'b1; ss_n_b = 1'b1; tx_load_a = 1'b0; tx_load_b = 1'b0;
    #50;
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_write(1'b0, 16'hA5C3);
    test_read(1'b0);
    test_abort(1'b0);
    test_load_busy(1'b0);
    test_write(1'b1, 16'hA5C3);
    test_read(1'b1);
    test_abort(1'b1);
    test_load_busy(1'b1);
    test_enable();
    test_random(1'b0, 12);
    test_random(1'b1, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
